// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: prioritised hold/flush, MDU busy sequencing, exception flush.
// Optional macro STALL_CNT_EN adds a stall_cycles output counting cycles with any hold bit set.
module pipeline_ctrl #(
    parameter int unsigned MDU_CYCLES = 32,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req_id,
    input  logic        stall_req_mem,
    input  logic        mdu_start,
    input  logic        exc_req,
    output logic [4:0]  hold,
    output logic [4:0]  flush,
    output logic        pc_redirect,
    output logic [31:0] new_pc,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic        mdu_abort
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic {
        RUN,
        MDU_WAIT
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(MDU_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ex_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // EX stalls on the start cycle itself and on every MDU_WAIT cycle until the count runs out.
    assign ex_stall = ((state_q == RUN) && mdu_start) ||
                      ((state_q == MDU_WAIT) && (cnt_q != 8'd0));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold        = 5'b00000;
        flush       = 5'b00000;
        pc_redirect = 1'b0;
        new_pc      = 32'd0;
        mdu_busy    = 1'b0;
        mdu_done    = 1'b0;
        mdu_abort   = 1'b0;

        if (rst) begin
            flush = 5'b11110;
        end else begin
            mdu_busy = (state_q == MDU_WAIT);
            if (exc_req) begin
                flush       = 5'b11110;
                pc_redirect = 1'b1;
                new_pc      = EXC_VECTOR;
                mdu_abort   = (state_q == MDU_WAIT);
                state_d     = RUN;
                cnt_d       = 8'd0;
            end else begin
                if (stall_req_mem) begin
                    hold  = 5'b01111;
                    flush = 5'b10000;
                end else if (ex_stall) begin
                    hold  = 5'b00111;
                    flush = 5'b01000;
                end else if (stall_req_id) begin
                    hold  = 5'b00011;
                    flush = 5'b00100;
                end

                // The MDU countdown keeps running through MEM stalls; a start under a MEM stall is retried.
                case (state_q)
                    RUN: begin
                        if (mdu_start && !stall_req_mem) begin
                            state_d = MDU_WAIT;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                    MDU_WAIT: begin
                        if (cnt_q != 8'd0) begin
                            cnt_d = cnt_q - 8'd1;
                        end else begin
                            mdu_done = 1'b1;
                            state_d  = RUN;
                        end
                    end
                    default: begin
                        state_d = RUN;
                        cnt_d   = 8'd0;
                    end
                endcase
            end
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else if (|hold) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (MDU_CYCLES=4): driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the combinational outputs.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req_id, stall_req_mem, mdu_start, exc_req;
    logic [4:0]  hold, flush;
    logic        pc_redirect;
    logic [31:0] new_pc;
    logic        mdu_busy, mdu_done, mdu_abort;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .MDU_CYCLES(4),
        .EXC_VECTOR(32'hBFC00380)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_req_id  (stall_req_id),
        .stall_req_mem (stall_req_mem),
        .mdu_start     (mdu_start),
        .exc_req       (exc_req),
        .hold          (hold),
        .flush         (flush),
        .pc_redirect   (pc_redirect),
        .new_pc        (new_pc),
        .mdu_busy      (mdu_busy),
        .mdu_done      (mdu_done),
        .mdu_abort     (mdu_abort)
`ifdef STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    typedef struct {
        string       name;
        logic [4:0]  hold;
        logic [4:0]  flush;
        logic        red;
        logic [31:0] pc;
        logic        busy;
        logic        done;
        logic        abort;
        logic        chk_sc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic vec(input string name, input logic r, input logic id, input logic mem,
                       input logic ms, input logic exc, input logic [4:0] h, input logic [4:0] f,
                       input logic red, input logic busy, input logic done, input logic abort,
                       input logic chk_sc = 1'b0, input logic [31:0] sc = 32'd0);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stall_req_id = id; stall_req_mem = mem; mdu_start = ms; exc_req = exc;
        e.name = name; e.hold = h; e.flush = f; e.red = red;
        e.pc = red ? 32'hBFC00380 : 32'd0;
        e.busy = busy; e.done = done; e.abort = abort; e.chk_sc = chk_sc; e.sc = sc;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every cycle presents one transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({hold, flush, pc_redirect, new_pc, mdu_busy, mdu_done, mdu_abort} !==
                    {e.hold, e.flush, e.red, e.pc, e.busy, e.done, e.abort}) begin
                    errors++;
                    $display("FAIL %s: got hold=%b flush=%b red=%b pc=%h busy=%b done=%b abort=%b, want hold=%b flush=%b red=%b pc=%h busy=%b done=%b abort=%b",
                             e.name, hold, flush, pc_redirect, new_pc, mdu_busy, mdu_done, mdu_abort,
                             e.hold, e.flush, e.red, e.pc, e.busy, e.done, e.abort);
                end else begin
                    $display("ok   %s: hold=%b flush=%b red=%b busy=%b done=%b abort=%b",
                             e.name, hold, flush, pc_redirect, mdu_busy, mdu_done, mdu_abort);
                end
`ifdef STALL_CNT_EN
                if (e.chk_sc) begin
                    checks++;
                    if (stall_cycles !== e.sc) begin
                        errors++;
                        $display("FAIL %s stall_cycles: got %0d want %0d", e.name, stall_cycles, e.sc);
                    end else begin
                        $display("ok   %s stall_cycles=%0d", e.name, stall_cycles);
                    end
                end
`endif
            end
        end
    end

    initial begin
        rst = 1'b1; stall_req_id = 1'b1; stall_req_mem = 1'b1; mdu_start = 1'b1; exc_req = 1'b1;
        //   name         rst id mem ms exc  hold      flush     red busy done abort
        vec("reset0",     1, 1, 1, 1, 1, 5'b00000, 5'b11110, 0, 0, 0, 0);
        vec("reset1",     1, 1, 1, 1, 1, 5'b00000, 5'b11110, 0, 0, 0, 0);
        vec("idle",       0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        vec("loaduse",    0, 1, 0, 0, 0, 5'b00011, 5'b00100, 0, 0, 0, 0);
        vec("after_id",   0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        // Plain MDU op: stall t..t+3, done at t+4
        vec("mdu_t0",     0, 0, 0, 1, 0, 5'b00111, 5'b01000, 0, 0, 0, 0);
        vec("mdu_t1",     0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 1, 0, 0);
        vec("mdu_t2",     0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 1, 0, 0);
        vec("mdu_t3",     0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 1, 0, 0);
        vec("mdu_done",   0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 1, 0);
        vec("mdu_after",  0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 1, 32'd5);
        // MDU op with a MEM stall at t+2; done still at t+4
        vec("mdum_t0",    0, 0, 0, 1, 0, 5'b00111, 5'b01000, 0, 0, 0, 0);
        vec("mdum_t1",    0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 1, 0, 0);
        vec("mdum_mem",   0, 0, 1, 0, 0, 5'b01111, 5'b10000, 0, 1, 0, 0);
        vec("mdum_t3",    0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 1, 0, 0);
        vec("mdum_done",  0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 1, 0);
        // Priority: MEM masks EX/ID and blocks MDU start; retry is accepted
        vec("prio_all",   0, 1, 1, 1, 0, 5'b01111, 5'b10000, 0, 0, 0, 0);
        vec("prio_retry", 0, 0, 0, 1, 0, 5'b00111, 5'b01000, 0, 0, 0, 0);
        vec("prio_t1_id", 0, 1, 0, 1, 0, 5'b00111, 5'b01000, 0, 1, 0, 0);
        vec("prio_t2",    0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 1, 0, 0);
        vec("prio_t3",    0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 1, 0, 0);
        vec("prio_done",  0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 1, 0);
        // Exception mid-MDU: abort, redirect, no done afterwards
        vec("exc_t0",     0, 0, 0, 1, 0, 5'b00111, 5'b01000, 0, 0, 0, 0);
        vec("exc_t1",     0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 1, 0, 0);
        vec("exc_hit",    0, 1, 1, 1, 1, 5'b00000, 5'b11110, 1, 1, 0, 1);
        vec("exc_t3",     0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        vec("exc_t4",     0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        vec("exc_t5",     0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        vec("exc_t6",     0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        // Exception in RUN: redirect without abort
        vec("exc_run",    0, 0, 0, 0, 1, 5'b00000, 5'b11110, 1, 0, 0, 0);
        // Reset mid-MDU: forced outputs, no done/abort pulse
        vec("rmdu_t0",    0, 0, 0, 1, 0, 5'b00111, 5'b01000, 0, 0, 0, 0);
        vec("rmdu_t1",    0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0, 1, 0, 0);
        vec("rmdu_rst",   1, 0, 0, 0, 0, 5'b00000, 5'b11110, 0, 0, 0, 0);
        vec("rmdu_a0",    0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 1, 32'd0);
        vec("rmdu_a1",    0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);
        vec("rmdu_a2",    0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
